// File: rtl/chan_grant_pkg.sv
// Shared types and helpers for the channel grant controller.
package chan_grant_pkg;

    localparam int MAX_CH = 32;

    typedef enum logic [1:0] {
        MODE_RR    = 2'd0,
        MODE_PRIO  = 2'd1,
        MODE_BCAST = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Index of the lowest set bit; returns 0 for an all-zero vector.
    function automatic logic [4:0] lowest_set_idx(input logic [MAX_CH-1:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/chan_grant_ctrl_rr_pick.sv
// Round-robin picker: first eligible channel at or after ptr, wrapping.
// The eligibility vector is doubled so a plain right shift acts as a rotate,
// then a priority encode of the rotated vector gives the offset from ptr.
module rr_pick
    import chan_grant_pkg::*;
#(
    parameter  int N_CH  = 5,
    localparam int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  onehot,
    output logic [IDX_W-1:0] idx
);

    logic [N_CH-1:0]  rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    // Rotate, priority-encode, then map the offset back to an absolute index.
    always_comb begin
        rot = N_CH'({elig, elig} >> ptr);
        off = IDX_W'(lowest_set_idx(MAX_CH'(rot)));
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDX_W + 1)'(N_CH)) begin
            sum = sum - (IDX_W + 1)'(N_CH);
        end
        idx    = IDX_W'(sum);
        onehot = N_CH'(1) << idx;
    end

endmodule

// File: rtl/chan_grant_ctrl.sv
// Registered request/grant controller with valid/ready hold and stall timeout.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no grant outstanding; eligible requests sampled each cycle
//  ST_GRANT | grant latched and valid; waiting for ready, abort or timeout
module chan_grant_ctrl
    import chan_grant_pkg::*;
#(
    parameter  int N_CH   = 5,
    parameter  int HOLD_W = 4,
    localparam int IDX_W  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    input  logic [N_CH-1:0]   req_i,
    input  logic [N_CH-1:0]   mask_i,
    input  logic              ready_i,
    output logic [N_CH-1:0]   grant_o,
    output logic              valid_o,
    output logic [IDX_W-1:0]  sel_idx_o,
    output logic              busy_o,
    output logic              timeout_o
);

    // Counter value seen on the last stalled cycle before the timeout fires.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((2 ** HOLD_W) - 2);
    localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(N_CH - 1);

    state_e            state_q,   state_d;
    mode_e             mode_q,    mode_d;
    logic [N_CH-1:0]   grant_q,   grant_d;
    logic [IDX_W-1:0]  sel_q,     sel_d;
    logic [IDX_W-1:0]  ptr_q,     ptr_d;
    logic [HOLD_W-1:0] hold_q,    hold_d;
    logic              timeout_q, timeout_d;

    logic [N_CH-1:0]   elig;
    logic [IDX_W-1:0]  low_idx;
    logic [N_CH-1:0]   rr_onehot;
    logic [IDX_W-1:0]  rr_idx;
    logic [IDX_W-1:0]  ptr_next;

    assign elig    = req_i & ~mask_i & {N_CH{en_i}};
    assign low_idx = IDX_W'(lowest_set_idx(MAX_CH'(elig)));
    assign ptr_next = (sel_q == IDX_MAX) ? '0 : sel_q + IDX_W'(1);

    rr_pick #(.N_CH(N_CH)) u_rr_pick (
        .elig   (elig),
        .ptr    (ptr_q),
        .onehot (rr_onehot),
        .idx    (rr_idx)
    );

    // State and output registers; reset drops the grant without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_RR;
            grant_q   <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state: select on entry, then resolve abort > ready > timeout > stall.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (elig != '0) begin
                    state_d = ST_GRANT;
                    mode_d  = mode_e'(mode_i);
                    hold_d  = '0;
                    case (mode_e'(mode_i))
                        MODE_RR: begin
                            grant_d = rr_onehot;
                            sel_d   = rr_idx;
                        end
                        MODE_BCAST: begin
                            grant_d = elig;
                            sel_d   = low_idx;
                        end
                        default: begin
                            grant_d = N_CH'(1) << low_idx;
                            sel_d   = low_idx;
                        end
                    endcase
                end
            end
            ST_GRANT: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    sel_d   = '0;
                end else if (ready_i || hold_q == HOLD_LAST) begin
                    // Completion and timeout both release the grant and advance the pointer.
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    sel_d     = '0;
                    timeout_d = !ready_i;
                    if (mode_q == MODE_RR) begin
                        ptr_d = ptr_next;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                sel_d   = '0;
            end
        endcase
    end

    assign grant_o   = grant_q;
    assign valid_o   = (state_q == ST_GRANT);
    assign busy_o    = (state_q != ST_IDLE);
    assign sel_idx_o = sel_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_chan_grant_ctrl.sv
// Bench for chan_grant_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_chan_grant_ctrl;

    localparam int NC = 5;
    localparam int HW = 4;
    localparam int TC = (1 << HW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [NC-1:0] req = '0;
    logic [NC-1:0] mask = '0;
    logic          ready = 1'b0;
    logic [NC-1:0] grant_o;
    logic          valid_o;
    logic [2:0]    sel_idx_o;
    logic          busy_o;
    logic          timeout_o;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    chan_grant_ctrl #(.N_CH(NC), .HOLD_W(HW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en),
        .mode_i    (mode),
        .req_i     (req),
        .mask_i    (mask),
        .ready_i   (ready),
        .grant_o   (grant_o),
        .valid_o   (valid_o),
        .sel_idx_o (sel_idx_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic int lowest(input logic [NC-1:0] v);
        for (int i = 0; i < NC; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int rr_first(input logic [NC-1:0] v, input int p);
        for (int k = 0; k < NC; k++) if (v[(p + k) % NC]) return (p + k) % NC;
        return 0;
    endfunction

    // Behavioural model: what the outputs must be after each edge.
    logic          m_valid = 1'b0;
    logic [NC-1:0] m_grant = '0;
    int            m_sel = 0;
    int            m_ptr = 0;
    int            m_cnt = 0;
    int            m_mode = 0;
    logic          m_to = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [NC-1:0] e;
        int s;
        if (!rst_n) begin
            m_valid <= 1'b0; m_grant <= '0; m_sel <= 0; m_ptr <= 0;
            m_cnt <= 0; m_mode <= 0; m_to <= 1'b0;
        end else begin
            m_to <= 1'b0;
            e = req & ~mask & {NC{en}};
            if (!m_valid) begin
                if (e != '0) begin
                    m_valid <= 1'b1;
                    m_cnt   <= 0;
                    m_mode  <= int'(mode);
                    if (mode == 2'd2) begin
                        m_grant <= e;
                        m_sel   <= lowest(e);
                    end else begin
                        s = (mode == 2'd0) ? rr_first(e, m_ptr) : lowest(e);
                        m_sel   <= s;
                        m_grant <= NC'(1) << s;
                    end
                end
            end else if (!en) begin
                m_valid <= 1'b0; m_grant <= '0; m_sel <= 0;
            end else if (ready || (m_cnt + 1 == TC)) begin
                m_valid <= 1'b0; m_grant <= '0; m_sel <= 0;
                if (!ready) m_to <= 1'b1;
                if (m_mode == 0) m_ptr <= (m_sel + 1) % NC;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Per-cycle comparison against the model, just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                chk("cyc_grant",   32'(grant_o),   32'(m_grant));
                chk("cyc_valid",   32'(valid_o),   32'(m_valid));
                chk("cyc_busy",    32'(busy_o),    32'(m_valid));
                chk("cyc_sel",     32'(sel_idx_o), 32'(m_sel));
                chk("cyc_timeout", 32'(timeout_o), 32'(m_to));
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk_en = 1'b1;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_sel", 32'(sel_idx_o), 32'h0);
        chk("rst_timeout", 32'(timeout_o), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // No requests: stays idle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_valid", 32'(valid_o), 32'h0);
            chk("idle_busy", 32'(busy_o), 32'h0);
        end

        // Round-robin with ready always high: 0,1,2,3,4,0 with bubbles.
        mode = 2'd0; req = 5'b11111; ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k % 2 == 1) begin
                chk("rr_valid", 32'(valid_o), 32'h1);
                chk("rr_grant", 32'(grant_o), 32'(5'b00001 << (((k - 1) / 2) % 5)));
            end else begin
                chk("rr_bubble", 32'(valid_o), 32'h0);
            end
        end
        req = '0; ready = 1'b0;    // pointer now 1

        // Fixed priority with a mask.
        @(negedge clk);
        mode = 2'd1; req = 5'b10110; mask = 5'b00010;
        @(negedge clk);
        chk("prio_grant", 32'(grant_o), 32'h04);
        chk("prio_sel", 32'(sel_idx_o), 32'd2);
        req = '0; mask = '0; ready = 1'b1;
        @(negedge clk);
        chk("prio_done", 32'(valid_o), 32'h0);
        ready = 1'b0;

        // Broadcast held until ready; input changes ignored.
        mode = 2'd2; req = 5'b01011;
        @(negedge clk);
        chk("bc_grant", 32'(grant_o), 32'h0B);
        chk("bc_sel", 32'(sel_idx_o), 32'd0);
        req = 5'b10100; mode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bc_hold", 32'(grant_o), 32'h0B);
        end
        ready = 1'b1; req = '0; mode = 2'd0;
        @(negedge clk);
        chk("bc_done", 32'(valid_o), 32'h0);
        ready = 1'b0;

        // Stall timeout: pointer 1, only channel 2 requests.
        req = 5'b00100;
        @(negedge clk);
        chk("to_grant", 32'(grant_o), 32'h04);
        req = '0;
        for (int k = 2; k <= 15; k++) begin
            @(negedge clk);
            chk("to_hold", 32'(valid_o), 32'h1);
            chk("to_early", 32'(timeout_o), 32'h0);
        end
        @(negedge clk);
        chk("to_pulse", 32'(timeout_o), 32'h1);
        chk("to_clear", 32'(grant_o), 32'h0);
        req = 5'b11111; ready = 1'b1;
        @(negedge clk);
        chk("to_ptr3", 32'(grant_o), 32'h08);
        chk("to_ptr3_sel", 32'(sel_idx_o), 32'd3);
        req = '0;
        @(negedge clk);
        ready = 1'b0;                // pointer now 4

        // Ready on the terminal cycle completes with no timeout.
        req = 5'b00100;
        @(negedge clk);
        chk("tc_grant", 32'(grant_o), 32'h04);
        req = '0;
        for (int k = 2; k <= 15; k++) @(negedge clk);
        chk("tc_still", 32'(valid_o), 32'h1);
        ready = 1'b1;
        @(negedge clk);
        chk("tc_done", 32'(valid_o), 32'h0);
        chk("tc_no_to", 32'(timeout_o), 32'h0);
        ready = 1'b0;                // pointer now 3

        // Enable drop with ready: abort, pointer unchanged.
        req = 5'b11111;
        @(negedge clk);
        chk("ab_grant", 32'(grant_o), 32'h08);
        @(negedge clk);
        @(negedge clk);
        en = 1'b0; ready = 1'b1;
        @(negedge clk);
        chk("ab_valid", 32'(valid_o), 32'h0);
        chk("ab_no_to", 32'(timeout_o), 32'h0);
        en = 1'b1; ready = 1'b0;
        @(negedge clk);
        chk("ab_ptr", 32'(grant_o), 32'h08);

        // Asynchronous reset in the middle of a grant.
        #2 rst_n = 1'b0;
        #1;
        chk("ar_grant", 32'(grant_o), 32'h0);
        chk("ar_valid", 32'(valid_o), 32'h0);
        chk("ar_busy", 32'(busy_o), 32'h0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req   = NC'($urandom);
            mask  = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
            en    = ($urandom_range(0, 19) != 0);
            mode  = 2'($urandom);
            ready = ((c / 200) % 3 == 2) ? 1'b0 : ($urandom_range(0, 7) == 0);
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
